pattern_sequencer: RTL and testbench
====================================

PATTERN_SEQUENCER -- requirements
Module: pattern_sequencer

Interface
- REQ-001 The block SHALL have parameter DATA_BIT, default 32, giving the pattern width; it matches the serial output block's DATA_BIT.
- REQ-002 The block SHALL have parameter DEPTH, default 4, giving the pattern table entry count; ADDR_BIT = clog2(DEPTH), default 2.
- REQ-003 The block SHALL have one clock and an asynchronous active-low reset:
  - clk  input  1  clock
  - rst_n  input  1  asynchronous active-low reset
- REQ-004 The block SHALL have these data, control and status ports:
  - i_wr_en  input  1  table write strobe
  - i_wr_addr  input  ADDR_BIT  table write index
  - i_wr_output  input  DATA_BIT  output pattern to store
  - i_wr_freq  input  DATA_BIT  frequency pattern to store
  - i_seq_len  input  ADDR_BIT+1  number of entries to play, valid range 1..DEPTH
  - i_run  input  1  start-sequence request
  - i_abort  input  1  abort request
  - i_loop  input  1  1 = restart at entry 0 after the last entry
  - i_done_tick  input  1  done pulse from the serial output block
  - o_start  output  1  start pulse to the serial output block
  - o_stop  output  1  stop pulse to the serial output block
  - o_output_pattern  output  DATA_BIT  current entry's output pattern
  - o_freq_pattern  output  DATA_BIT  current entry's frequency pattern
  - o_entry_idx  output  ADDR_BIT  index of the current entry
  - o_busy  output  1  high whenever the state is not S_IDLE
  - o_seq_done  output  1  one-cycle pulse on normal sequence completion

Function
- REQ-005 The block SHALL drive the serial output block in one-shot mode only; o_start and o_stop are registered one-cycle pulses.
- REQ-006 Table writes SHALL take effect on the clock edge when i_wr_en=1, in any state.
- REQ-007 The block SHALL implement four states: S_IDLE, S_START, S_WAIT, S_DONE.
- REQ-008 In S_IDLE, i_run=1 with 1<=i_seq_len<=DEPTH SHALL latch i_seq_len, set idx=0, load entry 0 into o_output_pattern/o_freq_pattern, and go to S_START.
- REQ-009 In S_IDLE, i_run with i_seq_len=0 or i_seq_len>DEPTH SHALL be ignored; the block stays in S_IDLE with no pulses.
- REQ-010 Entry load SHALL read the table before any same-edge write, so a write coincident with a load is seen only on the next pass.
- REQ-011 S_START SHALL assert o_start for exactly one cycle and then go to S_WAIT.
- REQ-012 o_output_pattern and o_freq_pattern SHALL stay stable from the load edge until the next load, so a write to the playing entry does not disturb it.
- REQ-013 In S_WAIT, i_done_tick=1 with idx < len-1 SHALL set idx=idx+1, load that entry, and go to S_START.
- REQ-014 In S_WAIT, i_done_tick=1 with idx = len-1 SHALL do one of:
  - i_loop=1: set idx=0, load entry 0, go to S_START;
  - otherwise: go to S_DONE.
- REQ-015 i_loop SHALL be sampled only at the last-entry done tick.
- REQ-016 S_DONE SHALL assert o_seq_done for one cycle and return to S_IDLE.
- REQ-017 Start-to-start latency SHALL be 2 cycles after the i_done_tick cycle (done tick -> S_START -> o_start high).
- REQ-018 i_abort=1 in S_START or S_WAIT SHALL pulse o_stop one cycle, go to S_IDLE, and produce no o_seq_done.
- REQ-019 i_abort SHALL take priority over a simultaneous i_done_tick.
- REQ-020 i_abort in S_IDLE or S_DONE SHALL be ignored.
- REQ-021 i_run outside S_IDLE SHALL be ignored; i_done_tick outside S_WAIT SHALL be ignored.
- REQ-022 o_entry_idx SHALL equal idx; idx SHALL wrap only through the loop rule, never by arithmetic overflow.

Reset
- REQ-023 rst_n=0 SHALL asynchronously force the following, at any time including mid-sequence:
  - state S_IDLE, idx 0, latched length 0;
  - o_start, o_stop, o_seq_done and o_busy low;
  - o_output_pattern and o_freq_pattern all zero;
  - all table entries zero.
- REQ-024 No o_stop pulse SHALL be generated by reset.

Verification
- REQ-025 Play 3 of 4: write entries 0..2 with output/freq 0xA5A5A5A5/0x0, 0x0000FFFF/0xFFFFFFFF, 0x1/0x0; i_seq_len=3, i_run -> 3 o_start pulses showing the three patterns in order, idx 0,1,2, each o_start 2 cycles after its preceding i_done_tick, one o_seq_done, then o_busy=0.
- REQ-026 Loop: i_seq_len=2, i_loop=1, five done ticks -> o_entry_idx sequence 0,1,0,1,0,1 and no o_seq_done; drop i_loop before the next last-entry tick -> o_seq_done pulses once.
- REQ-027 Abort with simultaneous done tick in S_WAIT, idx=1 -> o_stop pulses once, state S_IDLE, no o_start, no o_seq_done.
- REQ-028 Illegal length: i_seq_len=0 and then i_seq_len=5 with i_run -> o_busy stays 0 and no pulses.
- REQ-029 Write during play: overwrite entry 0 while entry 0 is in S_WAIT with a new value -> o_output_pattern unchanged until the next load; the loop pass shows the new value.
- REQ-030 Reset mid-S_WAIT -> all outputs zero in the same cycle, no o_stop, and a subsequent i_run plays all-zero patterns.

Source files
------------

// File: rtl/pattern_sequencer.sv
// Plays a short table of (output, frequency) pattern pairs into a one-shot serial
// output block: one start pulse per entry, advancing on each done tick from that block.
module pattern_sequencer #(
    parameter  int DATA_BIT = 32,
    parameter  int DEPTH    = 4,
    localparam int ADDR_BIT = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_wr_en,
    input  logic [ADDR_BIT-1:0] i_wr_addr,
    input  logic [DATA_BIT-1:0] i_wr_output,
    input  logic [DATA_BIT-1:0] i_wr_freq,
    input  logic [ADDR_BIT:0]   i_seq_len,
    input  logic                i_run,
    input  logic                i_abort,
    input  logic                i_loop,
    input  logic                i_done_tick,
    output logic                o_start,
    output logic                o_stop,
    output logic [DATA_BIT-1:0] o_output_pattern,
    output logic [DATA_BIT-1:0] o_freq_pattern,
    output logic [ADDR_BIT-1:0] o_entry_idx,
    output logic                o_busy,
    output logic                o_seq_done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state_reg;
    logic [ADDR_BIT-1:0] idx_reg;
    logic [ADDR_BIT:0]   len_reg;

    logic [DATA_BIT-1:0] out_tbl  [DEPTH];
    logic [DATA_BIT-1:0] freq_tbl [DEPTH];
    logic [DEPTH-1:0]    wr_hit;

    logic                len_ok;
    logic                is_last;
    logic [ADDR_BIT-1:0] idx_inc;

    // Per-entry write decode; addresses at or beyond DEPTH never hit.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_wr_dec
            assign wr_hit[gi] = i_wr_en && (i_wr_addr == ADDR_BIT'(gi));
        end
    endgenerate

    // The table is cleared by reset, so it lives in registers rather than RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                out_tbl[i]  <= '0;
                freq_tbl[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_hit[i]) begin
                    out_tbl[i]  <= i_wr_output;
                    freq_tbl[i] <= i_wr_freq;
                end
            end
        end
    end

    assign len_ok  = (i_seq_len != '0) && (i_seq_len <= (ADDR_BIT+1)'(DEPTH));
    assign is_last = (({1'b0, idx_reg} + (ADDR_BIT+1)'(1)) == len_reg);
    assign idx_inc = idx_reg + ADDR_BIT'(1);

    assign o_entry_idx = idx_reg;
    assign o_busy      = (state_reg != S_IDLE);

    // Table reads here see pre-edge contents, so a coincident write lands on the next pass.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= S_IDLE;
            idx_reg          <= '0;
            len_reg          <= '0;
            o_start          <= 1'b0;
            o_stop           <= 1'b0;
            o_seq_done       <= 1'b0;
            o_output_pattern <= '0;
            o_freq_pattern   <= '0;
        end else begin
            o_start    <= 1'b0;
            o_stop     <= 1'b0;
            o_seq_done <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (i_run && len_ok) begin
                        len_reg          <= i_seq_len;
                        idx_reg          <= '0;
                        o_output_pattern <= out_tbl[0];
                        o_freq_pattern   <= freq_tbl[0];
                        state_reg        <= S_START;
                    end
                end
                S_START: begin
                    if (i_abort) begin
                        o_stop    <= 1'b1;
                        state_reg <= S_IDLE;
                    end else begin
                        o_start   <= 1'b1;
                        state_reg <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (i_abort) begin
                        o_stop    <= 1'b1;
                        state_reg <= S_IDLE;
                    end else if (i_done_tick) begin
                        if (!is_last) begin
                            idx_reg          <= idx_inc;
                            o_output_pattern <= out_tbl[idx_inc];
                            o_freq_pattern   <= freq_tbl[idx_inc];
                            state_reg        <= S_START;
                        end else if (i_loop) begin
                            idx_reg          <= '0;
                            o_output_pattern <= out_tbl[0];
                            o_freq_pattern   <= freq_tbl[0];
                            state_reg        <= S_START;
                        end else begin
                            o_seq_done <= 1'b1;
                            state_reg  <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_sequencer.sv
// Randomized bench for pattern_sequencer: a transaction-level model predicts which
// entry each start pulse shows, the 2-cycle restart latency and the pulse counts.
module tb_pattern_sequencer;

    localparam int DATA_BIT = 32;
    localparam int DEPTH    = 4;
    localparam int ADDR_BIT = 2;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                i_wr_en = 1'b0;
    logic [ADDR_BIT-1:0] i_wr_addr = '0;
    logic [DATA_BIT-1:0] i_wr_output = '0;
    logic [DATA_BIT-1:0] i_wr_freq = '0;
    logic [ADDR_BIT:0]   i_seq_len = '0;
    logic                i_run = 1'b0;
    logic                i_abort = 1'b0;
    logic                i_loop = 1'b0;
    logic                i_done_tick = 1'b0;
    logic                o_start;
    logic                o_stop;
    logic [DATA_BIT-1:0] o_output_pattern;
    logic [DATA_BIT-1:0] o_freq_pattern;
    logic [ADDR_BIT-1:0] o_entry_idx;
    logic                o_busy;
    logic                o_seq_done;

    pattern_sequencer #(.DATA_BIT(DATA_BIT), .DEPTH(DEPTH)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_wr_en          (i_wr_en),
        .i_wr_addr        (i_wr_addr),
        .i_wr_output      (i_wr_output),
        .i_wr_freq        (i_wr_freq),
        .i_seq_len        (i_seq_len),
        .i_run            (i_run),
        .i_abort          (i_abort),
        .i_loop           (i_loop),
        .i_done_tick      (i_done_tick),
        .o_start          (o_start),
        .o_stop           (o_stop),
        .o_output_pattern (o_output_pattern),
        .o_freq_pattern   (o_freq_pattern),
        .o_entry_idx      (o_entry_idx),
        .o_busy           (o_busy),
        .o_seq_done       (o_seq_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cnt_start = 0;
    int cnt_stop = 0;
    int cnt_done = 0;

    logic [DATA_BIT-1:0] mdl_out  [DEPTH];
    logic [DATA_BIT-1:0] mdl_freq [DEPTH];

    // Pulse counters sample at the active edge, i.e. the value held over the previous cycle.
    always @(posedge clk) begin
        if (o_start)    cnt_start++;
        if (o_stop)     cnt_stop++;
        if (o_seq_done) cnt_done++;
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic write_entry(input int a, input logic [DATA_BIT-1:0] o, input logic [DATA_BIT-1:0] f);
        i_wr_en     = 1'b1;
        i_wr_addr   = ADDR_BIT'(a);
        i_wr_output = o;
        i_wr_freq   = f;
        step();
        i_wr_en     = 1'b0;
        mdl_out[a]  = o;
        mdl_freq[a] = f;
        $display("write entry=%0d out=%h freq=%h", a, o, f);
    endtask

    task automatic expect_start(input int idx);
        check_eq("o_start", 64'(o_start), 64'(1));
        check_eq("entry_idx", 64'(o_entry_idx), 64'(idx));
        check_eq("out_pattern", 64'(o_output_pattern), 64'(mdl_out[idx]));
        check_eq("freq_pattern", 64'(o_freq_pattern), 64'(mdl_freq[idx]));
        $display("start entry=%0d out=%h freq=%h", o_entry_idx, o_output_pattern, o_freq_pattern);
    endtask

    task automatic start_run(input int len);
        i_seq_len = (ADDR_BIT+1)'(len);
        i_run     = 1'b1;
        step();
        i_run = 1'b0;
        check_eq("busy_after_run", 64'(o_busy), 64'(1));
        check_eq("start_lat_first", 64'(o_start), 64'(0));
        step();
        expect_start(0);
    endtask

    // Idle cycles while waiting; stray run/len/loop values must all be ignored here.
    task automatic gap();
        repeat ($urandom_range(0, 3)) begin
            i_run     = 1'($urandom_range(0, 1));
            i_seq_len = (ADDR_BIT+1)'($urandom_range(0, 7));
            i_loop    = 1'($urandom_range(0, 1));
            step();
        end
        i_run = 1'b0;
    endtask

    // next_idx < 0 means the tick should complete the sequence.
    task automatic tick(input logic loop, input int next_idx);
        gap();
        i_done_tick = 1'b1;
        i_loop      = loop;
        step();
        i_done_tick = 1'b0;
        i_loop      = 1'($urandom_range(0, 1));
        if (next_idx >= 0) begin
            check_eq("start_lat_1cyc", 64'(o_start), 64'(0));
            check_eq("busy_restart", 64'(o_busy), 64'(1));
            step();
            expect_start(next_idx);
        end else begin
            check_eq("seq_done_pulse", 64'(o_seq_done), 64'(1));
            check_eq("busy_in_done", 64'(o_busy), 64'(1));
            step();
            check_eq("seq_done_clear", 64'(o_seq_done), 64'(0));
            check_eq("busy_final", 64'(o_busy), 64'(0));
            $display("sequence done");
        end
    endtask

    // mode: 0 abort+done in WAIT, 1 abort alone in WAIT, 2 abort in START.
    task automatic run_seq(input int len, input int passes, input int abort_t, input int mode);
        int total, s_start, s_stop, s_done, cur;
        bit aborted;
        total   = len * passes;
        s_start = cnt_start;
        s_stop  = cnt_stop;
        s_done  = cnt_done;
        aborted = 1'b0;
        $display("run len=%0d passes=%0d abort_t=%0d mode=%0d", len, passes, abort_t, mode);
        start_run(len);
        for (int t = 0; t < total; t++) begin
            cur = t % len;
            if (t == abort_t) begin
                gap();
                if (mode == 2) begin
                    i_done_tick = 1'b1;
                    i_loop      = 1'b1;
                    step();
                    i_done_tick = 1'b0;
                end
                i_abort     = 1'b1;
                i_done_tick = (mode == 0);
                step();
                i_abort     = 1'b0;
                i_done_tick = 1'b0;
                check_eq("stop_pulse", 64'(o_stop), 64'(1));
                check_eq("start_after_abort", 64'(o_start), 64'(0));
                check_eq("busy_after_abort", 64'(o_busy), 64'(0));
                step();
                check_eq("stop_clear", 64'(o_stop), 64'(0));
                check_eq("start_after_abort2", 64'(o_start), 64'(0));
                check_eq("seq_done_after_abort", 64'(o_seq_done), 64'(0));
                $display("abort at tick %0d", t);
                aborted = 1'b1;
                break;
            end
            if (cur != len - 1)      tick(1'($urandom_range(0, 1)), cur + 1);
            else if (t != total - 1) tick(1'b1, 0);
            else                     tick(1'b0, -1);
        end
        step();
        check_eq("cnt_start", 64'(cnt_start - s_start), aborted ? 64'(abort_t + 1) : 64'(total));
        check_eq("cnt_stop", 64'(cnt_stop - s_stop), aborted ? 64'(1) : 64'(0));
        check_eq("cnt_seq_done", 64'(cnt_done - s_done), aborted ? 64'(0) : 64'(1));
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_start"}, 64'(o_start), 64'(0));
        check_eq({tag, "_stop"}, 64'(o_stop), 64'(0));
        check_eq({tag, "_done"}, 64'(o_seq_done), 64'(0));
        check_eq({tag, "_busy"}, 64'(o_busy), 64'(0));
        check_eq({tag, "_idx"}, 64'(o_entry_idx), 64'(0));
        check_eq({tag, "_out"}, 64'(o_output_pattern), 64'(0));
        check_eq({tag, "_freq"}, 64'(o_freq_pattern), 64'(0));
    endtask

    initial begin
        int s_start, s_stop, s_done, len, passes, abort_t, mode;
        logic [DATA_BIT-1:0] old_out, old_freq;
        for (int i = 0; i < DEPTH; i++) begin
            mdl_out[i]  = '0;
            mdl_freq[i] = '0;
        end

        repeat (2) step();
        check_all_zero("reset");
        rst_n = 1'b1;
        step();

        // Play 3 of 4 with the reference patterns.
        write_entry(0, 32'hA5A5A5A5, 32'h0);
        write_entry(1, 32'h0000FFFF, 32'hFFFFFFFF);
        write_entry(2, 32'h1, 32'h0);
        run_seq(3, 1, -1, 0);

        // Loop a two-entry sequence three times, dropping loop on the final last-entry tick.
        run_seq(2, 3, -1, 0);

        // Abort coincident with a done tick while entry 1 is waiting.
        run_seq(3, 1, 1, 0);

        // Illegal lengths and stray abort/done in idle.
        s_start = cnt_start; s_stop = cnt_stop; s_done = cnt_done;
        i_abort = 1'b1; step(); i_abort = 1'b0;
        i_done_tick = 1'b1; step(); i_done_tick = 1'b0;
        i_seq_len = 3'd0; i_run = 1'b1; step(); i_run = 1'b0;
        check_eq("busy_len0", 64'(o_busy), 64'(0));
        i_seq_len = 3'd5; i_run = 1'b1; step(); i_run = 1'b0;
        check_eq("busy_len5", 64'(o_busy), 64'(0));
        step();
        check_eq("busy_idle_end", 64'(o_busy), 64'(0));
        check_eq("idle_no_start", 64'(cnt_start - s_start), 64'(0));
        check_eq("idle_no_stop", 64'(cnt_stop - s_stop), 64'(0));
        check_eq("idle_no_done", 64'(cnt_done - s_done), 64'(0));
        $display("idle/illegal-length checks done");

        // Overwrite the playing entry: held now, visible on the loop pass.
        start_run(2);
        old_out  = mdl_out[0];
        old_freq = mdl_freq[0];
        write_entry(0, 32'hDEADBEEF, 32'h12345678);
        check_eq("hold_out", 64'(o_output_pattern), 64'(old_out));
        check_eq("hold_freq", 64'(o_freq_pattern), 64'(old_freq));
        tick(1'b0, 1);
        tick(1'b1, 0);
        tick(1'b0, 1);
        tick(1'b0, -1);

        // Reset while waiting on entry 0.
        start_run(3);
        s_start = cnt_start; s_stop = cnt_stop;
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_rst");
        for (int i = 0; i < DEPTH; i++) begin
            mdl_out[i]  = '0;
            mdl_freq[i] = '0;
        end
        step();
        rst_n = 1'b1;
        step();
        check_eq("rst_no_stop", 64'(cnt_stop - s_stop), 64'(0));
        check_eq("rst_no_start", 64'(cnt_start - s_start), 64'(0));
        run_seq(2, 1, -1, 0);

        // Randomized sequences.
        for (int it = 0; it < 20; it++) begin
            repeat ($urandom_range(0, 4))
                write_entry($urandom_range(0, DEPTH - 1), $urandom, $urandom);
            len     = $urandom_range(1, DEPTH);
            passes  = $urandom_range(1, 3);
            abort_t = -1;
            mode    = 0;
            if ($urandom_range(0, 2) == 0) begin
                abort_t = $urandom_range(0, len * passes - 1);
                mode    = $urandom_range(0, 2);
            end
            run_seq(len, passes, abort_t, mode);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
